// File: rtl/xc_fifo_pkg.sv
// Shared types and default widths for the synchronous FIFO and its read-side drain stage.
package xc_fifo_pkg;

  localparam int unsigned DEF_WIDTH        = 32;
  localparam int unsigned DEF_BURST_LEN    = 4;
  localparam int unsigned DEF_LOG2_BURST   = 2;
  localparam int unsigned DEF_TIMEOUT      = 16;
  localparam int unsigned DEF_LOG2_TIMEOUT = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/xc_stream_reg_slice.sv
// Single-entry registered valid/ready stage; o_space_c tells the producer a load is accepted this cycle.
module xc_stream_reg_slice
  import xc_fifo_pkg::*;
#(
  parameter int unsigned PW = DEF_WIDTH + 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          i_load,
  input  logic [PW-1:0] i_payload,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [PW-1:0] o_payload,
  output logic          o_space_c
);

  logic          r_valid;
  logic [PW-1:0] r_payload;

  assign o_space_c = !r_valid || i_ready;
  assign o_valid   = r_valid;
  assign o_payload = r_payload;

  // Payload only changes on a load, so it is held while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (clr_i) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_payload <= i_payload;
    end else if (i_ready) begin
      r_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/xc_fifo_burst_drain.sv
// Drains a show-ahead FIFO in full bursts (almost-full) or short flush bursts (stall timeout)
// onto a registered valid/ready stream with start/end-of-packet markers.
module xc_fifo_burst_drain
  import xc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned BURST_LEN    = DEF_BURST_LEN,
  parameter int unsigned LOG2_BURST   = DEF_LOG2_BURST,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned LOG2_TIMEOUT = DEF_LOG2_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             fifo_ne_i,
  input  logic             fifo_af_i,
  input  logic             fifo_ae_i,
  output logic             fifo_rd_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_sop_o,
  output logic             m_eop_o,
  input  logic             m_ready_i,
  output logic             busy_o
);

  localparam int unsigned BW = LOG2_BURST + 1;
  localparam int unsigned TW = LOG2_TIMEOUT;
  localparam int unsigned PW = WIDTH + 2;

  state_e          r_state;
  logic [BW-1:0]   r_beat;
  logic [TW-1:0]   r_timer;
  logic            r_short;
  logic            r_busy;

  logic            w_space;
  logic            w_rd;
  logic            w_last;
  logic            w_sop;
  logic [PW-1:0]   w_payload;

  // Reads stall only on output space; clear suppresses the read in its own cycle.
  assign w_rd      = (r_state == ST_BURST) && fifo_ne_i && w_space && !clr_i;
  assign w_sop     = (r_beat == '0);
  assign w_last    = (r_beat == BW'(BURST_LEN - 1)) || (r_short && fifo_ae_i);
  assign fifo_rd_o = w_rd;
  assign busy_o    = r_busy;

  xc_stream_reg_slice #(
    .PW (PW)
  ) u_out_slice (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (clr_i),
    .i_load    (w_rd),
    .i_payload ({fifo_data_i, w_sop, w_last}),
    .i_ready   (m_ready_i),
    .o_valid   (m_valid_o),
    .o_payload (w_payload),
    .o_space_c (w_space)
  );

  assign {m_data_o, m_sop_o, m_eop_o} = w_payload;

  // Burst controller: almost-full wins over a timeout expiring in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_timer <= '0;
      r_short <= 1'b0;
      r_busy  <= 1'b0;
    end else if (clr_i) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_timer <= '0;
      r_short <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fifo_af_i) begin
            r_state <= ST_BURST;
            r_busy  <= 1'b1;
            r_short <= 1'b0;
            r_timer <= '0;
          end else if (fifo_ne_i) begin
            if (r_timer == TW'(TIMEOUT - 1)) begin
              r_state <= ST_BURST;
              r_busy  <= 1'b1;
              r_short <= 1'b1;
              r_timer <= '0;
            end else if (r_timer != {TW{1'b1}}) begin
              r_timer <= r_timer + TW'(1);
            end
          end else begin
            r_timer <= '0;
          end
        end
        ST_BURST: begin
          if (w_rd) begin
            if (w_last) begin
              r_beat  <= '0;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_beat  <= r_beat + BW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xc_fifo_burst_drain.sv
// Directed bench: behavioural show-ahead FIFO in front of the drain stage, beat log and hold monitor.
module tb_xc_fifo_burst_drain;

  localparam int unsigned W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         clr_i;
  logic [W-1:0] fifo_data_i;
  logic         fifo_ne_i;
  logic         fifo_af_i;
  logic         fifo_ae_i;
  logic         fifo_rd_o;
  logic         m_valid_o;
  logic [W-1:0] m_data_o;
  logic         m_sop_o;
  logic         m_eop_o;
  logic         m_ready_i;
  logic         busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  xc_fifo_burst_drain dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr_i),
    .fifo_data_i (fifo_data_i),
    .fifo_ne_i   (fifo_ne_i),
    .fifo_af_i   (fifo_af_i),
    .fifo_ae_i   (fifo_ae_i),
    .fifo_rd_o   (fifo_rd_o),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_sop_o     (m_sop_o),
    .m_eop_o     (m_eop_o),
    .m_ready_i   (m_ready_i),
    .busy_o      (busy_o)
  );

  // Behavioural FIFO: almost-full at >=4 words, almost-empty at <=1 word.
  logic [W-1:0] mem [16];
  logic [3:0]   wp, rp;
  logic [4:0]   cnt;
  logic         push, fclr;
  logic [W-1:0] push_d;

  assign fifo_data_i = mem[rp];
  assign fifo_ne_i   = (cnt != 5'd0);
  assign fifo_af_i   = (cnt >= 5'd4);
  assign fifo_ae_i   = (cnt <= 5'd1);

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp <= 4'd0; rp <= 4'd0; cnt <= 5'd0;
    end else if (fclr) begin
      wp <= 4'd0; rp <= 4'd0; cnt <= 5'd0;
    end else begin
      if (push) begin
        mem[wp] <= push_d;
        wp      <= wp + 4'd1;
      end
      if (fifo_rd_o) rp <= rp + 4'd1;
      cnt <= cnt + 5'(push) - 5'(fifo_rd_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [W-1:0] d, input logic s, input logic e);
    return 64'({d, s, e});
  endfunction

  // Event log sampled on the rising edge (pre-update values).
  int             cyc = 0;
  int             af_cyc;
  int             rd_cyc[$];
  logic [W+1:0]   got[$];
  logic           hold_chk, hold_pend;
  logic [W+1:0]   hold_v;

  always @(posedge clk_i) begin
    cyc++;
    hold_pend = 1'b0;
    if (!rst_i) begin
      if (m_valid_o && m_ready_i) got.push_back({m_data_o, m_sop_o, m_eop_o});
      if (fifo_rd_o) rd_cyc.push_back(cyc);
      if (fifo_af_i && af_cyc < 0) af_cyc = cyc;
      hold_pend = hold_chk && m_valid_o && !m_ready_i;
      hold_v    = {m_data_o, m_sop_o, m_eop_o};
    end
  end

  always @(negedge clk_i) begin
    if (hold_pend) chk("hold_stable", 64'({m_valid_o, m_data_o, m_sop_o, m_eop_o}), 64'({1'b1, hold_v}));
  end

  task automatic push_word(input logic [W-1:0] d);
    push = 1'b1; push_d = d;
    @(negedge clk_i);
    push = 1'b0;
  endtask

  task automatic wait_got(input string tag, input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    chk(tag, 64'(got.size()), 64'(n));
  endtask

  function automatic logic [63:0] got_at(input int i);
    return (i < got.size()) ? 64'(got[i]) : 64'(0);
  endfunction

  task automatic clear_logs();
    got.delete(); rd_cyc.delete(); af_cyc = -1;
  endtask

  initial begin
    int t0, k;
    logic any_eop;
    rst_i = 1'b1; clr_i = 1'b0; m_ready_i = 1'b1; push = 1'b0; push_d = '0;
    fclr = 1'b0; hold_chk = 1'b0; af_cyc = -1;
    repeat (2) @(negedge clk_i);
    chk("rst_outputs", 64'({m_valid_o, m_sop_o, m_eop_o, busy_o, fifo_rd_o}), 64'(0));
    chk("rst_data", 64'(m_data_o), 64'(0));
    rst_i = 1'b0;
    @(negedge clk_i);

    // 1: full burst of four words
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + W'(i));
    k = 0;
    while (rd_cyc.size() < 4 && k < 20) begin @(negedge clk_i); k++; end
    chk("t1_nreads", 64'(rd_cyc.size()), 64'(4));
    if (rd_cyc.size() >= 4) begin
      chk("t1_rd_start", 64'(rd_cyc[0]), 64'(af_cyc + 1));
      chk("t1_rd_contig", 64'(rd_cyc[3] - rd_cyc[0]), 64'(3));
    end
    chk("t1_busy_drop", 64'(busy_o), 64'(0));
    chk("t1_eop_held", 64'({m_valid_o, m_eop_o}), 64'(2'b11));
    wait_got("t1_nbeats", 4, 10);
    for (int i = 0; i < 4; i++)
      chk("t1_beat", got_at(i), beat(32'hA000_0000 + W'(i), i == 0, i == 3));

    // 2: two words then idle -> timeout flush burst
    clear_logs();
    t0 = cyc;
    push_word(32'hB000_0000);
    push_word(32'hB000_0001);
    k = 0;
    while (rd_cyc.size() < 1 && k < 40) begin @(negedge clk_i); k++; end
    chk("t2_first_rd", 64'(rd_cyc.size() > 0 ? rd_cyc[0] - t0 : 0), 64'(18));
    wait_got("t2_nbeats", 2, 10);
    chk("t2_beat0", got_at(0), beat(32'hB000_0000, 1'b1, 1'b0));
    chk("t2_beat1", got_at(1), beat(32'hB000_0001, 1'b0, 1'b1));
    chk("t2_timer", 64'(dut.r_timer), 64'(0));

    // 3: eight words with toggling ready
    clear_logs();
    hold_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; push_d = 32'hC000_0000 + W'(i);
      m_ready_i = (i % 2 == 0);
      @(negedge clk_i);
    end
    push = 1'b0;
    k = 0;
    while (got.size() < 8 && k < 60) begin
      m_ready_i = ~m_ready_i;
      @(negedge clk_i);
      k++;
    end
    hold_chk = 1'b0;
    m_ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("t3_nbeats", 64'(got.size()), 64'(8));
    for (int i = 0; i < 8; i++)
      chk("t3_beat", got_at(i), beat(32'hC000_0000 + W'(i), i % 4 == 0, i % 4 == 3));

    // 4: almost-full coincides with timeout expiry, leftover leaves as a short burst
    clear_logs();
    t0 = cyc;
    for (int i = 0; i < 3; i++) push_word(32'hD000_0000 + W'(i));
    repeat (12) @(negedge clk_i);
    for (int i = 3; i < 7; i++) push_word(32'hD000_0000 + W'(i));
    wait_got("t4_nbeats", 7, 80);
    for (int i = 0; i < 7; i++)
      chk("t4_beat", got_at(i), beat(32'hD000_0000 + W'(i), i == 0 || i == 4, i == 3 || i == 6));
    if (rd_cyc.size() >= 5) begin
      chk("t4_full_start", 64'(rd_cyc[0] - t0), 64'(18));
      chk("t4_flush_gap", 64'(rd_cyc[4] - rd_cyc[3]), 64'(17));
    end

    // 5: asynchronous reset mid-burst
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(32'hE000_0000 + W'(i));
    k = 0;
    while (rd_cyc.size() < 2 && k < 20) begin @(negedge clk_i); k++; end
    rst_i = 1'b1;
    #1;
    chk("t5_rst_outputs", 64'({m_valid_o, m_sop_o, m_eop_o, busy_o, fifo_rd_o}), 64'(0));
    chk("t5_rst_data", 64'(m_data_o), 64'(0));
    any_eop = 1'b0;
    foreach (got[i]) any_eop |= got[i][0];
    chk("t5_no_eop", 64'(any_eop), 64'(0));
    chk("t5_partial", 64'(got.size()), 64'(1));
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(32'hF000_0000 + W'(i));
    wait_got("t5_nbeats", 4, 20);
    for (int i = 0; i < 4; i++)
      chk("t5_beat", got_at(i), beat(32'hF000_0000 + W'(i), i == 0, i == 3));

    // 6: synchronous clear during a burst
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(32'h6000_0000 + W'(i));
    k = 0;
    while (rd_cyc.size() < 1 && k < 20) begin @(negedge clk_i); k++; end
    clr_i = 1'b1; fclr = 1'b1;
    #1;
    chk("t6_rd_in_clr", 64'(fifo_rd_o), 64'(0));
    @(negedge clk_i);
    clr_i = 1'b0; fclr = 1'b0;
    chk("t6_after_clr", 64'({busy_o, m_valid_o}), 64'(0));
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(32'h7000_0000 + W'(i));
    wait_got("t6_nbeats", 4, 20);
    for (int i = 0; i < 4; i++)
      chk("t6_beat", got_at(i), beat(32'h7000_0000 + W'(i), i == 0, i == 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
